// File: rtl/hyperram_pkg.sv
// Shared HyperRAM definitions: arbiter state encoding, abort read data and default geometry.
package hyperram_pkg;

   localparam int unsigned DEFAULT_MEMORY_BITS = 21;  // 2M x 32-bit words
   localparam logic [31:0] TIMEOUT_RDATA       = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } arb_state_e;

endpackage

// File: rtl/hyperram_arbiter_if.sv
// PicoRV32-native style word-access bus used by both requesters and the controller port.
interface hyperram_arbiter_if
   import hyperram_pkg::*;
#(
   parameter int unsigned MEMORY_BITS = DEFAULT_MEMORY_BITS
);
   logic                   valid;
   logic [MEMORY_BITS-1:0] addr;
   logic [31:0]            wdata;
   logic [3:0]             wstrb;
   logic                   ready;
   logic [31:0]            rdata;

   modport master (output valid, addr, wdata, wstrb, input ready, rdata);
   modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/rr_select2.sv
// Two-way winner pick: fixed priority to port 0, or round-robin favouring the port not in ptr_i.
module rr_select2 (
   input  logic [1:0] valid_i,
   input  logic       ptr_i,
   input  logic       fixed_i,
   output logic       winner_o
);

   always_comb begin
      winner_o = 1'b0;
      if (fixed_i) begin
         winner_o = ~valid_i[0];
      end else if (valid_i[~ptr_i]) begin
         winner_o = ~ptr_i;
      end else begin
         // Only one port can be requesting here, so pick whichever it is.
         winner_o = ~valid_i[0];
      end
   end

endmodule

// File: rtl/hyperram_arbiter.sv
// Arbitrates two requesters onto the single HyperRAM controller port, with a per-transaction
// watchdog that aborts a stuck access and returns TIMEOUT_RDATA to the owner.
module hyperram_arbiter
   import hyperram_pkg::*;
#(
   parameter int unsigned MEMORY_BITS    = DEFAULT_MEMORY_BITS,
   parameter int unsigned FIXED_PRIORITY = 0,
   parameter int unsigned TIMEOUT        = 1023
) (
   input  logic               clk,
   input  logic               nreset,
   hyperram_arbiter_if.slave  p0,
   hyperram_arbiter_if.slave  p1,
   hyperram_arbiter_if.master ctl,
   output logic               timeout_err,
   output logic               last_grant
);

   // Counter only needs to reach TIMEOUT-1; the abort fires on the following BUSY edge.
   localparam int unsigned    WdogW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 1);

   arb_state_e             state_q, state_d;
   logic                   owner_q, owner_d;
   logic                   rr_ptr_q, rr_ptr_d;
   logic [WdogW-1:0]       wdog_q, wdog_d;
   logic                   ctl_valid_q, ctl_valid_d;
   logic [MEMORY_BITS-1:0] ctl_addr_q, ctl_addr_d;
   logic [31:0]            ctl_wdata_q, ctl_wdata_d;
   logic [3:0]             ctl_wstrb_q, ctl_wstrb_d;
   logic [1:0]             rdy_q, rdy_d;
   logic [31:0]            rdata0_q, rdata0_d;
   logic [31:0]            rdata1_q, rdata1_d;
   logic                   timeout_err_q, timeout_err_d;
   logic                   last_grant_q, last_grant_d;

   logic [1:0] req;
   logic       winner;
   logic       wdog_expire;

   assign req         = {p1.valid, p0.valid};
   assign wdog_expire = (TIMEOUT != 0) && (wdog_q == WdogLast);

   rr_select2 u_rr_select2 (
      .valid_i  (req),
      .ptr_i    (rr_ptr_q),
      .fixed_i  (FIXED_PRIORITY != 0),
      .winner_o (winner)
   );

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      wdog_d        = wdog_q;
      ctl_valid_d   = ctl_valid_q;
      ctl_addr_d    = ctl_addr_q;
      ctl_wdata_d   = ctl_wdata_q;
      ctl_wstrb_d   = ctl_wstrb_q;
      rdy_d         = 2'b00;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
      timeout_err_d = timeout_err_q;
      last_grant_d  = last_grant_q;

      case (state_q)
         StIdle: begin
            if (|req) begin
               ctl_valid_d  = 1'b1;
               ctl_addr_d   = winner ? p1.addr  : p0.addr;
               ctl_wdata_d  = winner ? p1.wdata : p0.wdata;
               ctl_wstrb_d  = winner ? p1.wstrb : p0.wstrb;
               owner_d      = winner;
               rr_ptr_d     = winner;
               last_grant_d = winner;
               wdog_d       = '0;
               state_d      = StBusy;
            end
         end
         StBusy: begin
            // A completion in the same cycle as the watchdog expiry takes precedence.
            if (ctl.ready) begin
               ctl_valid_d    = 1'b0;
               rdy_d[owner_q] = 1'b1;
               if (owner_q) rdata1_d = ctl.rdata;
               else         rdata0_d = ctl.rdata;
               state_d        = StDone;
            end else if (wdog_expire) begin
               ctl_valid_d    = 1'b0;
               rdy_d[owner_q] = 1'b1;
               if (owner_q) rdata1_d = TIMEOUT_RDATA;
               else         rdata0_d = TIMEOUT_RDATA;
               timeout_err_d  = 1'b1;
               state_d        = StDone;
            end else begin
               wdog_d = wdog_q + WdogW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q       <= StIdle;
         owner_q       <= 1'b0;
         rr_ptr_q      <= 1'b1;
         wdog_q        <= '0;
         ctl_valid_q   <= 1'b0;
         ctl_addr_q    <= '0;
         ctl_wdata_q   <= '0;
         ctl_wstrb_q   <= '0;
         rdy_q         <= 2'b00;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
         timeout_err_q <= 1'b0;
         last_grant_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         wdog_q        <= wdog_d;
         ctl_valid_q   <= ctl_valid_d;
         ctl_addr_q    <= ctl_addr_d;
         ctl_wdata_q   <= ctl_wdata_d;
         ctl_wstrb_q   <= ctl_wstrb_d;
         rdy_q         <= rdy_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
         timeout_err_q <= timeout_err_d;
         last_grant_q  <= last_grant_d;
      end
   end

   assign ctl.valid   = ctl_valid_q;
   assign ctl.addr    = ctl_addr_q;
   assign ctl.wdata   = ctl_wdata_q;
   assign ctl.wstrb   = ctl_wstrb_q;
   assign p0.ready    = rdy_q[0];
   assign p0.rdata    = rdata0_q;
   assign p1.ready    = rdy_q[1];
   assign p1.rdata    = rdata1_q;
   assign timeout_err = timeout_err_q;
   assign last_grant  = last_grant_q;

endmodule

// File: tb/tb_hyperram_arbiter.sv
// Directed bench: a round-robin arbiter (TIMEOUT=15) and a fixed-priority one, each behind a
// small controller emulator with a 256-word memory and a stall control.
module tb_hyperram_arbiter;
   import hyperram_pkg::*;

   localparam int unsigned AW = 21;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   hyperram_arbiter_if #(.MEMORY_BITS(AW)) rr_p0 ();
   hyperram_arbiter_if #(.MEMORY_BITS(AW)) rr_p1 ();
   hyperram_arbiter_if #(.MEMORY_BITS(AW)) rr_ctl ();
   hyperram_arbiter_if #(.MEMORY_BITS(AW)) fp_p0 ();
   hyperram_arbiter_if #(.MEMORY_BITS(AW)) fp_p1 ();
   hyperram_arbiter_if #(.MEMORY_BITS(AW)) fp_ctl ();

   logic rr_terr, rr_lg, fp_terr, fp_lg;

   hyperram_arbiter #(.MEMORY_BITS(AW), .FIXED_PRIORITY(0), .TIMEOUT(15)) u_dut_rr (
      .clk         (clk),
      .nreset      (nreset),
      .p0          (rr_p0),
      .p1          (rr_p1),
      .ctl         (rr_ctl),
      .timeout_err (rr_terr),
      .last_grant  (rr_lg)
   );

   hyperram_arbiter #(.MEMORY_BITS(AW), .FIXED_PRIORITY(1), .TIMEOUT(0)) u_dut_fp (
      .clk         (clk),
      .nreset      (nreset),
      .p0          (fp_p0),
      .p1          (fp_p1),
      .ctl         (fp_ctl),
      .timeout_err (fp_terr),
      .last_grant  (fp_lg)
   );

   // Controller emulator: answers three cycles after ctl_valid unless stalled.
   logic [1:0]    em_valid, em_ready, stall;
   logic [AW-1:0] em_addr [2];
   logic [31:0]   em_wdata [2];
   logic [31:0]   em_rdata [2];
   logic [3:0]    em_wstrb [2];

   assign em_valid[0] = rr_ctl.valid;
   assign em_addr[0]  = rr_ctl.addr;
   assign em_wdata[0] = rr_ctl.wdata;
   assign em_wstrb[0] = rr_ctl.wstrb;
   assign rr_ctl.ready = em_ready[0];
   assign rr_ctl.rdata = em_rdata[0];
   assign em_valid[1] = fp_ctl.valid;
   assign em_addr[1]  = fp_ctl.addr;
   assign em_wdata[1] = fp_ctl.wdata;
   assign em_wstrb[1] = fp_ctl.wstrb;
   assign fp_ctl.ready = em_ready[1];
   assign fp_ctl.rdata = em_rdata[1];

   for (genvar g = 0; g < 2; g++) begin : g_emu
      logic [31:0] mem [256];
      logic [1:0]  cnt;
      logic        rdy_q;
      logic [31:0] rdata_q;
      always @(posedge clk) begin
         if (!nreset) begin
            cnt   <= 2'd0;
            rdy_q <= 1'b0;
         end else begin
            rdy_q <= 1'b0;
            if (em_valid[g] && !rdy_q && !stall[g]) begin
               if (cnt == 2'd2) begin
                  rdy_q   <= 1'b1;
                  rdata_q <= mem[em_addr[g][7:0]];
                  for (int b = 0; b < 4; b++) begin
                     if (em_wstrb[g][b]) mem[em_addr[g][7:0]][8*b +: 8] <= em_wdata[g][8*b +: 8];
                  end
                  cnt <= 2'd0;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end else if (!em_valid[g]) begin
               cnt <= 2'd0;
            end
         end
      end
      assign em_ready[g] = rdy_q;
      assign em_rdata[g] = rdata_q;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic rr_drive(input bit port, input bit v, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic [3:0] s);
      if (!port) begin
         rr_p0.valid = v; rr_p0.addr = a; rr_p0.wdata = d; rr_p0.wstrb = s;
      end else begin
         rr_p1.valid = v; rr_p1.addr = a; rr_p1.wdata = d; rr_p1.wstrb = s;
      end
   endtask

   task automatic fp_drive(input bit port, input bit v, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic [3:0] s);
      if (!port) begin
         fp_p0.valid = v; fp_p0.addr = a; fp_p0.wdata = d; fp_p0.wstrb = s;
      end else begin
         fp_p1.valid = v; fp_p1.addr = a; fp_p1.wdata = d; fp_p1.wstrb = s;
      end
   endtask

   // One transaction on the round-robin DUT; returns after the ready cycle with valid dropped.
   task automatic rr_txn(input bit port, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
      int  n = 0;
      bit  got = 1'b0;
      logic other;
      rr_drive(port, 1'b1, a, d, s);
      while (!got && n < 60) begin
         @(posedge clk); #1;
         n++;
         got = port ? rr_p1.ready : rr_p0.ready;
      end
      rd    = port ? rr_p1.rdata : rr_p0.rdata;
      other = port ? rr_p0.ready : rr_p1.ready;
      rr_drive(port, 1'b0, a, d, s);
      check("txn_ready", got, 1);
      check("txn_other_ready", other, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [31:0] rd, rd0, rd1;
      int n, cyc, done0, done1, guard;
      int order[$];
      int exp_rr[4];
      int exp_fp[8];
      exp_rr = '{0, 1, 0, 1};
      exp_fp = '{0, 0, 0, 0, 1, 1, 1, 1};
      stall = 2'b00;
      rr_drive(0, 0, '0, '0, '0);
      rr_drive(1, 0, '0, '0, '0);
      fp_drive(0, 0, '0, '0, '0);
      fp_drive(1, 0, '0, '0, '0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl_valid", rr_ctl.valid, 0);
      check("rst_ctl_addr", rr_ctl.addr, 0);
      check("rst_ctl_wstrb", rr_ctl.wstrb, 0);
      check("rst_p0_ready", rr_p0.ready, 0);
      check("rst_p1_ready", rr_p1.ready, 0);
      check("rst_p0_rdata", rr_p0.rdata, 0);
      check("rst_terr", rr_terr, 0);
      check("rst_last_grant", rr_lg, 0);
      nreset = 1'b1;

      // Single write then detailed read
      rr_txn(0, 21'h10, 32'h1234_5678, 4'hF, rd);
      @(posedge clk); #1;
      rr_drive(0, 1, 21'h10, 32'h0, 4'h0);
      @(posedge clk); #1;
      check("rd_ctl_valid", rr_ctl.valid, 1);
      check("rd_ctl_addr", rr_ctl.addr, 21'h10);
      check("rd_ctl_wstrb", rr_ctl.wstrb, 0);
      check("rd_last_grant", rr_lg, 0);
      n = 0;
      while (!rr_ctl.ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("rd_ctl_ready_seen", rr_ctl.ready, 1);
      @(posedge clk); #1;
      check("rd_p0_ready", rr_p0.ready, 1);
      check("rd_p0_rdata", rr_p0.rdata, 32'h1234_5678);
      check("rd_p1_ready", rr_p1.ready, 0);
      check("rd_ctl_dropped", rr_ctl.valid, 0);
      rr_drive(0, 0, 21'h10, 32'h0, 4'h0);
      @(posedge clk); #1;
      check("rd_p0_pulse_end", rr_p0.ready, 0);
      check("rd_p0_rdata_hold", rr_p0.rdata, 32'h1234_5678);

      // Round-robin contention after a fresh reset
      nreset = 1'b0;
      @(posedge clk); #1;
      nreset = 1'b1;
      rr_drive(0, 1, 21'h20, 32'hAAAA_0000, 4'hF);
      rr_drive(1, 1, 21'h40, 32'h5555_0000, 4'hF);
      done0 = 0; done1 = 0; guard = 0;
      while ((done0 < 2 || done1 < 2) && guard < 200) begin
         @(posedge clk); #1;
         guard++;
         if (rr_p0.ready) begin
            order.push_back(0);
            done0++;
            rr_drive(0, done0 < 2, 21'h20 + AW'(done0), 32'hAAAA_0000 + done0, 4'hF);
         end
         if (rr_p1.ready) begin
            order.push_back(1);
            done1++;
            rr_drive(1, done1 < 2, 21'h40 + AW'(done1), 32'h5555_0000 + done1, 4'hF);
         end
      end
      check("rr_count", order.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rr_order%0d", i), (i < order.size()) ? order[i] : 9, exp_rr[i]);
      end
      rr_txn(0, 21'h20, 0, 0, rd); check("rr_mem_20", rd, 32'hAAAA_0000);
      rr_txn(0, 21'h21, 0, 0, rd); check("rr_mem_21", rd, 32'hAAAA_0001);
      rr_txn(1, 21'h40, 0, 0, rd); check("rr_mem_40", rd, 32'h5555_0000);
      rr_txn(1, 21'h41, 0, 0, rd); check("rr_mem_41", rd, 32'h5555_0001);

      // Byte strobes on port 1
      rr_txn(1, 21'h50, 32'h1122_3344, 4'hF, rd);
      rr_txn(1, 21'h50, 32'h00CD_0000, 4'b0100, rd);
      rr_txn(1, 21'h50, 32'h0, 4'h0, rd);
      check("strb_readback", rd, 32'h11CD_3344);

      // Watchdog abort with a stalled controller
      stall[0] = 1'b1;
      rr_drive(0, 1, 21'h10, 32'h0, 4'h0);
      n = 0;
      while (!rr_ctl.valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("to_ctl_rise", rr_ctl.valid, 1);
      cyc = 0;
      while (rr_ctl.valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("to_valid_cycles", cyc, 15);
      check("to_p0_ready", rr_p0.ready, 1);
      check("to_p0_rdata", rr_p0.rdata, TIMEOUT_RDATA);
      check("to_p1_ready", rr_p1.ready, 0);
      check("to_err_set", rr_terr, 1);
      rr_drive(0, 0, 21'h10, 32'h0, 4'h0);
      stall[0] = 1'b0;
      @(posedge clk); #1;
      rr_txn(0, 21'h10, 0, 0, rd);
      check("to_next_rdata", rd, 32'h1234_5678);
      check("to_err_sticky", rr_terr, 1);

      // Fixed priority: port 0 drains all four before port 1
      fp_drive(0, 1, 21'h60, 32'hAAAA_0000, 4'hF);
      fp_drive(1, 1, 21'h70, 32'h5555_0000, 4'hF);
      order.delete();
      done0 = 0; done1 = 0; guard = 0;
      while ((done0 < 4 || done1 < 4) && guard < 300) begin
         @(posedge clk); #1;
         guard++;
         if (fp_p0.ready) begin
            order.push_back(0);
            done0++;
            fp_drive(0, done0 < 4, 21'h60 + AW'(done0), 32'hAAAA_0000 + done0, 4'hF);
         end
         if (fp_p1.ready) begin
            order.push_back(1);
            done1++;
            fp_drive(1, done1 < 4, 21'h70 + AW'(done1), 32'h5555_0000 + done1, 4'hF);
         end
      end
      check("fp_count", order.size(), 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("fp_order%0d", i), (i < order.size()) ? order[i] : 9, exp_fp[i]);
      end
      check("fp_terr", fp_terr, 0);

      // Asynchronous reset while BUSY
      stall[0] = 1'b1;
      rr_drive(0, 1, 21'h10, 32'h0, 4'h0);
      n = 0;
      while (!rr_ctl.valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("rst_mid_busy", rr_ctl.valid, 1);
      repeat (3) @(posedge clk);
      #3;
      nreset = 1'b0;
      #1;
      check("rst_mid_ctl_valid", rr_ctl.valid, 0);
      check("rst_mid_terr", rr_terr, 0);
      check("rst_mid_p0_ready", rr_p0.ready, 0);
      rr_drive(0, 0, 21'h10, 32'h0, 4'h0);
      stall[0] = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_no_pulse", rr_p0.ready, 0);
      nreset = 1'b1;
      rr_drive(0, 1, 21'h21, 32'h0, 4'h0);
      rr_drive(1, 1, 21'h41, 32'h0, 4'h0);
      @(posedge clk); #1;
      check("post_rst_grant_valid", rr_ctl.valid, 1);
      check("post_rst_last_grant", rr_lg, 0);
      check("post_rst_addr", rr_ctl.addr, 21'h21);
      done0 = 0; done1 = 0; guard = 0; rd0 = '0; rd1 = '0;
      while ((done0 < 1 || done1 < 1) && guard < 100) begin
         @(posedge clk); #1;
         guard++;
         if (rr_p0.ready) begin
            rd0 = rr_p0.rdata; done0++;
            rr_drive(0, 0, 21'h21, 32'h0, 4'h0);
         end
         if (rr_p1.ready) begin
            rd1 = rr_p1.rdata; done1++;
            rr_drive(1, 0, 21'h41, 32'h0, 4'h0);
         end
      end
      check("post_rst_p0_rdata", rd0, 32'hAAAA_0001);
      check("post_rst_p1_rdata", rd1, 32'h5555_0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hyperram_arbiter.md
Name: hyperram_arbiter

Overview:
- Shares the single HyperRAM controller port between two PicoRV32-native-style requesters: port 0 is the CPU, port 1 is a DMA or video fetch engine.
- Sits between the requesters and the HyperRAM controller inside main, on clk.
- Registers each granted request, forwards it downstream as a word access, and returns rdata with a one-cycle ready pulse to the owner.
- Provides round-robin or fixed-priority arbitration and a per-transaction watchdog.

Parameters:
MEMORY_BITS, 21, word-address width of the HyperRAM (2Mx32).
FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins a simultaneous request.
TIMEOUT, 1023, clk cycles allowed between ctl_valid rise and ctl_ready before abort; 0 disables the watchdog.

Ports:
clk  in  1  system clock (also drives the controller interface).
nreset  in  1  asynchronous active-low reset.
p0_valid  in  1  port 0 request.
p0_addr  in  MEMORY_BITS  port 0 word address.
p0_wdata  in  32  port 0 write data.
p0_wstrb  in  4  port 0 byte strobes; 0 = read.
p0_ready  out  1  port 0 completion pulse.
p0_rdata  out  32  port 0 read data, valid while p0_ready=1.
p1_valid, p1_addr, p1_wdata, p1_wstrb, p1_ready, p1_rdata: same as port 0.
ctl_valid  out  1  request to the HyperRAM controller.
ctl_addr  out  MEMORY_BITS  registered word address.
ctl_wdata  out  32  registered write data.
ctl_wstrb  out  4  registered strobes.
ctl_ready  in  1  controller completion, one cycle.
ctl_rdata  in  32  controller read data, valid with ctl_ready.
timeout_err  out  1  sticky, set on watchdog abort.
last_grant  out  1  port served by the most recent grant (debug/LED).

Behaviour:
Reset:
- All outputs are 0, state IDLE, rr pointer = 1, so port 0 wins the first conflict.
- Asynchronous assertion aborts any transaction immediately: ctl_valid drops and no ready pulse is issued.
States IDLE -> BUSY -> DONE -> IDLE.
IDLE:
- If any pX_valid is high, choose the winner:
  - FIXED_PRIORITY=1: port 0 if p0_valid.
  - Otherwise: the port not equal to the rr pointer if it is requesting, else the requesting port.
- Latch addr/wdata/wstrb into ctl_*, set ctl_valid=1, set owner and rr pointer to the winner, clear the watchdog counter, go to BUSY.
- Latency: valid seen at edge n -> ctl_valid=1 after edge n.
BUSY:
- ctl_valid held high and ctl_* held stable.
- On ctl_ready: ctl_valid=0 next cycle, p<owner>_rdata=ctl_rdata, p<owner>_ready=1 for exactly one cycle, go to DONE.
- Watchdog: the counter increments each BUSY cycle. When it reaches TIMEOUT without ctl_ready: ctl_valid=0, owner gets ready=1 with rdata=32'hFFFFFFFF, timeout_err=1, go to DONE.
- A ctl_ready arriving in the same cycle as the timeout wins: normal completion, no error.
DONE:
- One turnaround cycle so the owner can drop valid; no new grant is made.
- Returns to IDLE; a still-pending request from the other port is granted at the next IDLE edge.
Rules:
- ctl_ready while not BUSY is ignored.
- The non-owner's ready is always 0.
- Requester inputs are sampled only in IDLE; changes in BUSY have no effect.
- A requester withdrawing valid mid-transaction still receives its ready pulse.
- pX_rdata holds its last value when ready=0.
- Throughput: one transaction per (controller latency + 3) cycles.
- timeout_err clears only on reset.

Decomposition:
- Shared package hyperram_pkg holds:
  - state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - TIMEOUT_RDATA = 32'hFFFFFFFF;
  - the MEMORY_BITS default shared with the controller and emulator.
- One natural sub-module, rr_select2: combinational 2-way round-robin/fixed-priority pick with inputs valid[1:0], ptr, fixed and output winner.
- Everything else stays in hyperram_arbiter.

Test Plan:
- Single read: p0 read addr 0x000010 after a controller write of 0x12345678 -> ctl_addr=0x10, ctl_wstrb=0; p0_ready pulses one cycle after ctl_ready with p0_rdata=0x12345678; p1_ready stays 0.
- Simultaneous contention, round-robin: p0 and p1 both write continuously (0xAAAA0000+n, 0x55550000+n) -> grants alternate 0,1,0,1; first grant to p0 after reset; emulator memory matches all data.
- Fixed priority: FIXED_PRIORITY=1 with both requesting 4 times -> all four p0 grants complete before any p1 grant.
- Byte strobes: p1 write wstrb=4'b0100 data 0x00CD0000 over 0x11223344 -> readback 0x11CD3344.
- Timeout: controller never asserts ctl_ready, TIMEOUT=15 -> ctl_valid drops 15 cycles after rising; p0_ready=1 with rdata 0xFFFFFFFF; timeout_err=1 and stays 1; the next request is served normally.
- Reset mid-transaction: nreset low while BUSY -> ctl_valid=0 and timeout_err=0 immediately, no ready pulse; after release, p0 wins the first conflict.
